// File: rtl/spi_cmd_regfile.sv
// Commits completed 40-bit SPI frames into the CLOCK_50 domain: validates CS-low
// duration and reserved bits, updates a command register file, counts frames/errors.
module spi_cmd_regfile #(
    parameter int MIN_LOW    = 64,
    parameter int SETTLE_CYC = 4,
    parameter int NREG       = 16,
    localparam int IW        = $clog2(NREG),
    localparam int SW        = $clog2(SETTLE_CYC + 1)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          spi_cs,
    input  logic [39:0]   q_frame,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    output logic [7:0]    addr_latched,
    output logic          wr_pulse,
    output logic [IW-1:0] wr_idx,
    output logic          frame_valid,
    output logic [15:0]   frame_count,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {IDLE, FRAME, SETTLE, CHECK} state_t;

    state_t        state, state_n;
    logic          cs_m, cs_s, cs_prev;
    logic          cs_fall, cs_rise;
    logic [15:0]   low_cnt, low_cnt_n;
    logic [SW-1:0] set_cnt, set_cnt_n;
    logic [7:0]    err_count_n, addr_latched_n;
    logic [15:0]   frame_count_n;
    logic          wr_pulse_n, frame_valid_n;
    logic [IW-1:0] wr_idx_n;
    logic [31:0]   wr_data, wr_data_n;
    logic          reject;
    logic [31:0]   regs [NREG];

    assign cs_fall = cs_prev & ~cs_s;
    assign cs_rise = ~cs_prev & cs_s;
    assign reject  = (low_cnt < 16'(MIN_LOW)) || (q_frame[39] && (q_frame[38:36] != 3'b000));
    assign rd_data = regs[rd_idx];

    // Synchronizer idles high so reset never fabricates a CS edge on its own.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cs_m    <= 1'b1;
            cs_s    <= 1'b1;
            cs_prev <= 1'b1;
        end else begin
            cs_m    <= spi_cs;
            cs_s    <= cs_m;
            cs_prev <= cs_s;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            low_cnt      <= '0;
            set_cnt      <= '0;
            err_count    <= '0;
            frame_count  <= '0;
            addr_latched <= '0;
            wr_pulse     <= 1'b0;
            wr_idx       <= '0;
            wr_data      <= '0;
            frame_valid  <= 1'b0;
        end else begin
            state        <= state_n;
            low_cnt      <= low_cnt_n;
            set_cnt      <= set_cnt_n;
            err_count    <= err_count_n;
            frame_count  <= frame_count_n;
            addr_latched <= addr_latched_n;
            wr_pulse     <= wr_pulse_n;
            wr_idx       <= wr_idx_n;
            wr_data      <= wr_data_n;
            frame_valid  <= frame_valid_n;
        end
    end

    always_comb begin
        state_n        = state;
        low_cnt_n      = low_cnt;
        set_cnt_n      = set_cnt;
        err_count_n    = err_count;
        frame_count_n  = frame_count;
        addr_latched_n = addr_latched;
        wr_pulse_n     = 1'b0;
        frame_valid_n  = 1'b0;
        wr_idx_n       = wr_idx;
        wr_data_n      = wr_data;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n   = FRAME;
                    low_cnt_n = '0;
                end
            end
            FRAME: begin
                if (low_cnt != 16'hFFFF) low_cnt_n = low_cnt + 16'd1;
                if (cs_rise) begin
                    state_n   = SETTLE;
                    set_cnt_n = '0;
                end
            end
            SETTLE: begin
                // A fall before sampling means q may be mid-shift: drop the frame.
                if (cs_fall) begin
                    if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
                    state_n   = FRAME;
                    low_cnt_n = '0;
                end else begin
                    set_cnt_n = set_cnt + SW'(1);
                    if (set_cnt == SW'(SETTLE_CYC - 1)) state_n = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
                end else begin
                    frame_valid_n  = 1'b1;
                    frame_count_n  = frame_count + 16'd1;
                    addr_latched_n = q_frame[39:32];
                    if (q_frame[39]) begin
                        wr_pulse_n = 1'b1;
                        wr_idx_n   = q_frame[32 +: IW];
                        wr_data_n  = q_frame[31:0];
                    end
                end
                if (cs_s) begin
                    state_n = IDLE;
                end else begin
                    state_n   = FRAME;
                    low_cnt_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register write lands one cycle after the strobe.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_pulse) begin
            regs[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Randomized and directed checks of spi_cmd_regfile against a frame-level model.
module tb_spi_cmd_regfile;
    localparam int MIN_LOW = 64;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        spi_cs;
    logic [39:0] q_frame;
    logic [3:0]  rd_idx;
    logic [31:0] rd_data;
    logic [7:0]  addr_latched;
    logic        wr_pulse;
    logic [3:0]  wr_idx;
    logic        frame_valid;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    spi_cmd_regfile dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .spi_cs(spi_cs), .q_frame(q_frame),
        .rd_idx(rd_idx), .rd_data(rd_data), .addr_latched(addr_latched),
        .wr_pulse(wr_pulse), .wr_idx(wr_idx), .frame_valid(frame_valid),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] regs_m [16];
    logic [15:0] fc_m;
    logic [7:0]  err_m;
    logic [7:0]  addr_m;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) regs_m[i] = '0;
        fc_m = '0; err_m = '0; addr_m = '0;
    endtask

    function automatic bit accepts(input logic [39:0] q, input int low_cyc);
        return (low_cyc >= MIN_LOW) && !(q[39] && q[38:36] != 3'b000);
    endfunction

    // Called right after the raw CS rise; observes the next 11 cycles.
    task automatic check_window(input logic [39:0] q, input bit acc, input int fall_at);
        logic [3:0] idx;
        idx    = q[35:32];
        rd_idx = idx;
        if (acc) begin
            fc_m++;
            addr_m = q[39:32];
            if (q[39]) regs_m[idx] = q[31:0];
        end else if (err_m != 8'hFF) begin
            err_m++;
        end
        for (int i = 1; i <= 11; i++) begin
            @(negedge CLOCK_50);
            chk("frame_valid", 40'(frame_valid), 40'((i == 8) && acc));
            chk("wr_pulse", 40'(wr_pulse), 40'((i == 8) && acc && q[39]));
            if (i == 8 && acc && q[39]) chk("wr_idx", 40'(wr_idx), 40'(idx));
            if (i == 9) begin
                chk("rd_data", 40'(rd_data), 40'(regs_m[idx]));
                chk("frame_count", 40'(frame_count), 40'(fc_m));
                chk("err_count", 40'(err_count), 40'(err_m));
                chk("addr_latched", 40'(addr_latched), 40'(addr_m));
            end
            if (i == fall_at) spi_cs = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [39:0] q, input int low_cyc);
        q_frame = q;
        spi_cs  = 1'b0;
        repeat (low_cyc) @(negedge CLOCK_50);
        spi_cs = 1'b1;
        check_window(q, accepts(q, low_cyc), 0);
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_cs = 1'b1; q_frame = '0; rd_idx = '0;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_wr_pulse", 40'(wr_pulse), 40'(0));
        chk("rst_frame_valid", 40'(frame_valid), 40'(0));
        chk("rst_frame_count", 40'(frame_count), 40'(0));
        chk("rst_err_count", 40'(err_count), 40'(0));
        chk("rst_addr", 40'(addr_latched), 40'(0));
        for (int i = 0; i < 16; i += 5) begin
            rd_idx = 4'(i); #1;
            chk("rst_reg", 40'(rd_data), 40'(0));
        end
    endtask

    task automatic test_directed();
        run_frame(40'h83DEADBEEF, 2000);
        run_frame(40'h0500000000, 2000);
        rd_idx = 4'd3; #1;
        chk("reg3_after_read", 40'(rd_data), 40'(32'hDEADBEEF));
        run_frame(40'h8112345678, 20);
        run_frame(40'h9100000001, 200);
        rd_idx = 4'd1; #1;
        chk("reg1_unchanged", 40'(rd_data), 40'(regs_m[1]));
    endtask

    task automatic test_glitch();
        logic [7:0] base;
        base    = err_m;
        q_frame = 40'h8AA5A5A5A5;
        spi_cs  = 1'b0;
        repeat (200) @(negedge CLOCK_50);
        spi_cs = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        spi_cs = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        spi_cs = 1'b1;
        for (int j = 6; j <= 24; j++) begin
            @(negedge CLOCK_50);
            chk("glitch_no_fv", 40'(frame_valid), 40'(0));
            chk("glitch_no_wp", 40'(wr_pulse), 40'(0));
            if (j == 9) chk("glitch_abort_err", 40'(err_count), 40'(base + 8'd1));
        end
        err_m = base + 8'd2;  // abort, then the 2-cycle remnant is a runt
        chk("glitch_err_total", 40'(err_count), 40'(err_m));
        rd_idx = 4'hA; #1;
        chk("glitch_regA", 40'(rd_data), 40'(regs_m[10]));
        run_frame(40'h8A0BADF00D, 150);
    endtask

    task automatic test_back_to_back();
        logic [39:0] qa, qb;
        qa = 40'h87CAFEF00D;
        qb = 40'h8E13572468;
        q_frame = qa;
        spi_cs  = 1'b0;
        repeat (150) @(negedge CLOCK_50);
        spi_cs = 1'b1;
        check_window(qa, 1'b1, 5);
        q_frame = qb;
        repeat (150) @(negedge CLOCK_50);
        spi_cs = 1'b1;
        check_window(qb, 1'b1, 0);
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [39:0] q;
            int          l;
            q = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) q[38:36] = 3'b000;
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(100, 300);
            run_frame(q, l);
        end
    endtask

    task automatic test_readback();
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i); #1;
            chk("readback", 40'(rd_data), 40'(regs_m[i]));
        end
    endtask

    task automatic test_err_saturation();
        for (int n = 0; n < 260; n++) run_frame(40'h0100000000, 8);
        chk("err_saturated", 40'(err_count), 40'(8'hFF));
        run_frame(40'h8FFFFFFFFF, 120);
        chk("post_sat_count", 40'(frame_count), 40'(fc_m));
    endtask

    task automatic test_reset_midframe();
        rd_idx  = 4'd3;
        run_frame(40'h8312345678, 100);
        q_frame = 40'h8200000022;
        spi_cs  = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        spi_cs = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_strobe", 40'({wr_pulse, frame_valid}), 40'(0));
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < 20; j++) begin
            @(negedge CLOCK_50);
            chk("post_rst_no_fv", 40'(frame_valid), 40'(0));
        end
        rd_idx = 4'd3; #1;
        chk("post_rst_reg3", 40'(rd_data), 40'(0));
        chk("post_rst_fc", 40'(frame_count), 40'(0));
        chk("post_rst_err", 40'(err_count), 40'(0));
        run_frame(40'h8300000777, 100);
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_directed();
                test_glitch();
                test_back_to_back();
                test_random();
                test_readback();
                test_err_saturation();
                test_reset_midframe();
                test_readback();
            end
            begin
                #20ms;
                failures++;
                $display("FAIL timeout: bench did not complete");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
